// File: rtl/bsg_fifo_dest_pkg.sv
// Shared constants and types for the bridge destination scheduler and its merge arbiter.
package bsg_fifo_dest_pkg;
  localparam int DEST_SEL_LSB   = 16;
  localparam int DEST_SEL_WIDTH = 4;
  localparam int DROP_CNT_W     = 16;
  localparam int CMD_ADDR_W     = 32;
  localparam int CMD_DATA_W     = 32;

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} stage_e;

  typedef struct packed {
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] data;
  } cmd_s;
endpackage

// File: rtl/bsg_fifo_dest_scheduler_if.sv
// Bundle of the scheduler's command, per-endpoint and merged-return signals.
interface bsg_fifo_dest_scheduler_if
  import bsg_fifo_dest_pkg::*;
#(
  parameter int num_dest_p   = 4,
  parameter int addr_width_p = 32,
  parameter int data_width_p = 32
);
  logic                               cmd_v, cmd_yumi;
  logic [addr_width_p-1:0]            cmd_addr, dest_addr;
  logic [data_width_p-1:0]            cmd_data, dest_data, mrg_data;
  logic [num_dest_p-1:0]              dest_v, dest_ready, dest_credit;
  logic [num_dest_p-1:0]              ret_v, ret_yumi;
  logic [num_dest_p*data_width_p-1:0] ret_data;
  logic                               mrg_v, mrg_ready, credit_err;
  logic [DROP_CNT_W-1:0]              drop_count;

  // master: bridge/endpoint side driving the scheduler
  modport master (
    output cmd_v, cmd_addr, cmd_data, dest_ready, dest_credit, ret_v, ret_data, mrg_ready,
    input  cmd_yumi, dest_v, dest_addr, dest_data, ret_yumi, mrg_v, mrg_data, drop_count, credit_err
  );
  modport slave (
    input  cmd_v, cmd_addr, cmd_data, dest_ready, dest_credit, ret_v, ret_data, mrg_ready,
    output cmd_yumi, dest_v, dest_addr, dest_data, ret_yumi, mrg_v, mrg_data, drop_count, credit_err
  );
endinterface

// File: rtl/bsg_fifo_dest_rr_arb.sv
// Round-robin arbiter: search starts at the pointer, pointer moves past the winner on yumi.
module bsg_fifo_dest_rr_arb #(
  parameter int num_p = 4
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic [num_p-1:0] v_i,
  input  logic             yumi_i,
  output logic [num_p-1:0] grant_o,
  output logic             v_o
);
  localparam int PW = (num_p > 1) ? $clog2(num_p) : 1;

  logic [PW-1:0] r_ptr, w_win;
  logic          w_found;

  always_comb begin
    grant_o = '0;
    w_win   = '0;
    w_found = 1'b0;
    for (int i = 0; i < num_p; i++) begin
      int idx;
      idx = (int'(r_ptr) + i) % num_p;
      if (!w_found && v_i[idx]) begin
        w_found      = 1'b1;
        w_win        = PW'(idx);
        grant_o[idx] = 1'b1;
      end
    end
  end

  assign v_o = w_found;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)         r_ptr <= '0;
    else if (yumi_i && v_o) r_ptr <= (int'(w_win) == num_p-1) ? '0 : w_win + PW'(1);
  end
endmodule

// File: rtl/bsg_fifo_dest_scheduler.sv
// Dispatches the bridge command stream to credited endpoints and merges their returns.
module bsg_fifo_dest_scheduler
  import bsg_fifo_dest_pkg::*;
#(
  parameter int num_dest_p       = 4,
  parameter int addr_width_p     = 32,
  parameter int data_width_p     = 32,
  parameter int dest_sel_lsb_p   = DEST_SEL_LSB,
  parameter int dest_sel_width_p = DEST_SEL_WIDTH,
  parameter int max_credits_p    = 8
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic                               v_i,
  input  logic [addr_width_p-1:0]            addr_i,
  input  logic [data_width_p-1:0]            data_i,
  output logic                               yumi_o,
  output logic [num_dest_p-1:0]              dest_v_o,
  output logic [addr_width_p-1:0]            dest_addr_o,
  output logic [data_width_p-1:0]            dest_data_o,
  input  logic [num_dest_p-1:0]              dest_ready_i,
  input  logic [num_dest_p-1:0]              dest_credit_i,
  input  logic [num_dest_p-1:0]              ret_v_i,
  input  logic [num_dest_p*data_width_p-1:0] ret_data_i,
  output logic [num_dest_p-1:0]              ret_yumi_o,
  output logic                               v_o,
  output logic [data_width_p-1:0]            data_o,
  input  logic                               ready_i,
  output logic [DROP_CNT_W-1:0]              drop_count_o,
  output logic                               credit_err_o
);
  localparam int CW = $clog2(max_credits_p + 1);
  localparam logic [CW-1:0] MAXC = CW'(max_credits_p);

  stage_e                          r_state, w_state_nxt;
  logic [num_dest_p-1:0]           r_dest_v;
  logic [addr_width_p-1:0]         r_addr;
  logic [data_width_p-1:0]         r_data;
  logic [num_dest_p-1:0][CW-1:0]   r_credit;
  logic [DROP_CNT_W-1:0]           r_drop;
  logic                            r_credit_err;

  logic [dest_sel_width_p-1:0]     w_sel;
  logic [num_dest_p-1:0]           w_sel_oh, w_has_credit, w_dec, w_ovf, w_grant;
  logic                            w_sel_ok, w_hs, w_stage_free, w_accept, w_drop, w_arb_v;

  assign w_sel = addr_i[dest_sel_lsb_p +: dest_sel_width_p];

  // An out-of-range select matches no endpoint, which is what marks it for dropping.
  always_comb begin
    w_sel_oh     = '0;
    w_has_credit = '0;
    for (int k = 0; k < num_dest_p; k++) begin
      w_sel_oh[k]     = (w_sel == dest_sel_width_p'(k));
      w_has_credit[k] = (r_credit[k] != '0);
    end
  end
  assign w_sel_ok = |w_sel_oh;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= ST_EMPTY;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
      ST_FULL:  if (w_accept) w_state_nxt = ST_FULL;
                else if (w_hs) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  always_comb begin
    w_hs         = |(r_dest_v & dest_ready_i);
    w_stage_free = (r_state == ST_EMPTY) || w_hs;
    w_accept     = reset_n_i & v_i & w_sel_ok & w_stage_free & |(w_sel_oh & w_has_credit);
    w_drop       = reset_n_i & v_i & ~w_sel_ok;
    yumi_o       = w_accept | w_drop;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_dest_v <= '0;
      r_addr   <= '0;
      r_data   <= '0;
    end else if (w_accept) begin
      r_dest_v <= w_sel_oh;
      r_addr   <= addr_i;
      r_data   <= data_i;
    end else if (w_hs) begin
      r_dest_v <= '0;
    end
  end

  assign w_dec = w_sel_oh & {num_dest_p{w_accept}};
  always_comb begin
    w_ovf = '0;
    for (int k = 0; k < num_dest_p; k++)
      w_ovf[k] = dest_credit_i[k] & ~w_dec[k] & (r_credit[k] == MAXC);
  end

  // Simultaneous return and spend cancel; a return at max is held and flagged.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_credit <= {num_dest_p{MAXC}};
    end else begin
      for (int k = 0; k < num_dest_p; k++) begin
        if (dest_credit_i[k] && !w_dec[k]) begin
          if (r_credit[k] != MAXC) r_credit[k] <= r_credit[k] + CW'(1);
        end else if (w_dec[k] && !dest_credit_i[k]) begin
          r_credit[k] <= r_credit[k] - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_drop       <= '0;
      r_credit_err <= 1'b0;
    end else begin
      if (w_drop && r_drop != '1) r_drop <= r_drop + DROP_CNT_W'(1);
      if (|w_ovf)                 r_credit_err <= 1'b1;
    end
  end

  assign dest_v_o     = r_dest_v;
  assign dest_addr_o  = r_addr;
  assign dest_data_o  = r_data;
  assign drop_count_o = r_drop;
  assign credit_err_o = r_credit_err;

  bsg_fifo_dest_rr_arb #(.num_p(num_dest_p)) u_ret_arb (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (ret_v_i),
    .yumi_i    (ready_i & reset_n_i),
    .grant_o   (w_grant),
    .v_o       (w_arb_v)
  );

  always_comb begin
    data_o = '0;
    for (int k = 0; k < num_dest_p; k++)
      if (w_grant[k]) data_o = data_o | ret_data_i[k*data_width_p +: data_width_p];
  end

  assign v_o        = reset_n_i & w_arb_v;
  assign ret_yumi_o = w_grant & {num_dest_p{ready_i & reset_n_i}};
endmodule

// File: tb/tb_bsg_fifo_dest_scheduler.sv
// Directed scoreboard bench for the destination scheduler (dispatch, credits, drops, merge arbiter).
module tb_bsg_fifo_dest_scheduler;
  import bsg_fifo_dest_pkg::*;
  localparam int N = 4, AW = 32, DW = 32;

  logic gclk = 1'b0, rst_n = 1'b0;
  always #5 gclk = ~gclk;

  bsg_fifo_dest_scheduler_if #(.num_dest_p(N), .addr_width_p(AW), .data_width_p(DW)) bif ();

  bsg_fifo_dest_scheduler #(.num_dest_p(N), .addr_width_p(AW), .data_width_p(DW)) dut (
    .clk_i(gclk), .reset_n_i(rst_n),
    .v_i(bif.cmd_v), .addr_i(bif.cmd_addr), .data_i(bif.cmd_data), .yumi_o(bif.cmd_yumi),
    .dest_v_o(bif.dest_v), .dest_addr_o(bif.dest_addr), .dest_data_o(bif.dest_data),
    .dest_ready_i(bif.dest_ready), .dest_credit_i(bif.dest_credit),
    .ret_v_i(bif.ret_v), .ret_data_i(bif.ret_data), .ret_yumi_o(bif.ret_yumi),
    .v_o(bif.mrg_v), .data_o(bif.mrg_data), .ready_i(bif.mrg_ready),
    .drop_count_o(bif.drop_count), .credit_err_o(bif.credit_err)
  );

  typedef struct {logic [N-1:0] v; cmd_s c;} dsp_t;
  typedef struct {logic [N-1:0] g; logic [DW-1:0] d;} ret_t;
  dsp_t dsp_q[$];
  ret_t ret_q[$];
  int n_vec = 0, n_err = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Sample point: scoreboard pops on every dispatch or merge handshake seen this cycle.
  task automatic at_neg();
    dsp_t e;
    ret_t r;
    @(negedge gclk);
    if (|(bif.dest_v & bif.dest_ready)) begin
      chk("dsp_sb_pending", 64'(dsp_q.size() != 0), 64'(1));
      if (dsp_q.size() != 0) begin
        e = dsp_q.pop_front();
        chk("dsp_v", 64'(bif.dest_v), 64'(e.v));
        chk("dsp_addr", 64'(bif.dest_addr), 64'(e.c.addr));
        chk("dsp_data", 64'(bif.dest_data), 64'(e.c.data));
      end
    end
    if (bif.mrg_v && bif.mrg_ready) begin
      chk("ret_sb_pending", 64'(ret_q.size() != 0), 64'(1));
      if (ret_q.size() != 0) begin
        r = ret_q.pop_front();
        chk("ret_yumi", 64'(bif.ret_yumi), 64'(r.g));
        chk("ret_data", 64'(bif.mrg_data), 64'(r.d));
      end
    end
  endtask

  task automatic at_pos();
    @(posedge gclk);
    #1;
  endtask

  task automatic cyc();
    at_neg();
    at_pos();
  endtask

  task automatic push_dsp(logic [N-1:0] v, logic [AW-1:0] a, logic [DW-1:0] d);
    dsp_t e;
    e.v = v; e.c.addr = a; e.c.data = d;
    dsp_q.push_back(e);
  endtask

  task automatic push_ret(logic [N-1:0] g, logic [DW-1:0] d);
    ret_t r;
    r.g = g; r.d = d;
    ret_q.push_back(r);
  endtask

  task automatic cmd(logic v, logic [AW-1:0] a, logic [DW-1:0] d);
    bif.cmd_v = v; bif.cmd_addr = a; bif.cmd_data = d;
  endtask

  initial begin
    cmd(1'b1, 32'h0002_0000, 32'h1);
    bif.dest_ready = '1; bif.dest_credit = '0;
    bif.ret_v = 4'hF; bif.ret_data = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
    bif.mrg_ready = 1'b1;
    #2;
    chk("rst_dest_v", 64'(bif.dest_v), 64'(0));
    chk("rst_addr", 64'(bif.dest_addr), 64'(0));
    chk("rst_data", 64'(bif.dest_data), 64'(0));
    chk("rst_yumi", 64'(bif.cmd_yumi), 64'(0));
    chk("rst_mrg_v", 64'(bif.mrg_v), 64'(0));
    chk("rst_ret_yumi", 64'(bif.ret_yumi), 64'(0));
    chk("rst_drop", 64'(bif.drop_count), 64'(0));
    chk("rst_err", 64'(bif.credit_err), 64'(0));
    cmd(1'b0, '0, '0); bif.ret_v = '0; bif.mrg_ready = 1'b0;
    at_pos(); at_pos();
    rst_n = 1'b1;

    // single command to endpoint 2
    cmd(1'b1, 32'h0002_0000, 32'hA5A5_A5A5);
    at_neg(); chk("t1_yumi", 64'(bif.cmd_yumi), 64'(1));
    push_dsp(4'b0100, 32'h0002_0000, 32'hA5A5_A5A5);
    at_pos(); chk("t1_credit2", 64'(dut.r_credit[2]), 64'(7));
    cmd(1'b0, '0, '0);
    cyc();

    // 9 back-to-back to endpoint 1; 9th waits for a credit
    for (int i = 0; i < 9; i++) begin
      cmd(1'b1, 32'h0001_0000 + 32'(i), 32'hB000_0000 + 32'(i));
      at_neg(); chk("t2_yumi", 64'(bif.cmd_yumi), 64'(i < 8));
      if (i < 8) push_dsp(4'b0010, 32'h0001_0000 + 32'(i), 32'hB000_0000 + 32'(i));
      at_pos();
    end
    at_neg(); chk("t2_stall", 64'(bif.cmd_yumi), 64'(0)); at_pos();
    bif.dest_credit = 4'b0010;
    at_neg(); chk("t2_stall_crd", 64'(bif.cmd_yumi), 64'(0)); at_pos();
    bif.dest_credit = '0;
    at_neg(); chk("t2_9th_yumi", 64'(bif.cmd_yumi), 64'(1));
    push_dsp(4'b0010, 32'h0001_0008, 32'hB000_0008);
    at_pos();
    cmd(1'b0, '0, '0);
    cyc();

    // endpoint 0 back-pressure holds the stage; release gives back-to-back dispatch
    bif.dest_ready = 4'b1110;
    cmd(1'b1, 32'h0000_0010, 32'h1111_1111);
    at_neg(); chk("t3_yumi", 64'(bif.cmd_yumi), 64'(1));
    push_dsp(4'b0001, 32'h0000_0010, 32'h1111_1111);
    at_pos();
    cmd(1'b1, 32'h0002_0020, 32'h2222_2222);
    for (int i = 0; i < 5; i++) begin
      at_neg();
      chk("t3_hold_v", 64'(bif.dest_v), 64'(4'b0001));
      chk("t3_hold_addr", 64'(bif.dest_addr), 64'(32'h0000_0010));
      chk("t3_hold_data", 64'(bif.dest_data), 64'(32'h1111_1111));
      chk("t3_hold_yumi", 64'(bif.cmd_yumi), 64'(0));
      at_pos();
    end
    bif.dest_ready = '1;
    at_neg(); chk("t3_b2b_yumi", 64'(bif.cmd_yumi), 64'(1));
    push_dsp(4'b0100, 32'h0002_0020, 32'h2222_2222);
    at_pos();
    cmd(1'b0, '0, '0);
    cyc();

    // bad destination drops and saturating counter
    cmd(1'b1, 32'h000C_0000, 32'hDEAD_0000);
    at_neg(); chk("t4_yumi", 64'(bif.cmd_yumi), 64'(1)); at_pos();
    cmd(1'b0, '0, '0);
    at_neg();
    chk("t4_no_dest_v", 64'(bif.dest_v), 64'(0));
    chk("t4_drop1", 64'(bif.drop_count), 64'(1));
    at_pos();
    cmd(1'b1, 32'h000C_0000, 32'hDEAD_0001);
    repeat (65533) @(posedge gclk);
    #1; chk("t4_drop_fffe", 64'(bif.drop_count), 64'(16'hFFFE));
    repeat (4466) @(posedge gclk);
    #1; chk("t4_drop_sat", 64'(bif.drop_count), 64'(16'hFFFF));
    cmd(1'b0, '0, '0);

    // merge arbiter: rotation, frozen pointer, wrap
    bif.ret_v = 4'hF; bif.mrg_ready = 1'b1;
    push_ret(4'b0001, 32'hD000_0000); push_ret(4'b0010, 32'hD000_0001);
    push_ret(4'b0100, 32'hD000_0002); push_ret(4'b1000, 32'hD000_0003);
    push_ret(4'b0001, 32'hD000_0000);
    repeat (5) cyc();
    bif.mrg_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      at_neg();
      chk("t5_frz_v", 64'(bif.mrg_v), 64'(1));
      chk("t5_frz_data", 64'(bif.mrg_data), 64'(32'hD000_0001));
      chk("t5_frz_yumi", 64'(bif.ret_yumi), 64'(0));
      at_pos();
    end
    bif.mrg_ready = 1'b1;
    push_ret(4'b0010, 32'hD000_0001);
    cyc();
    bif.ret_v = 4'b0001;
    push_ret(4'b0001, 32'hD000_0000);
    cyc();
    bif.ret_v = '0;
    at_neg();
    chk("t5_idle_v", 64'(bif.mrg_v), 64'(0));
    chk("t5_idle_data", 64'(bif.mrg_data), 64'(0));
    at_pos();
    bif.mrg_ready = 1'b0;

    // simultaneous spend and return, then overflow flag
    cmd(1'b1, 32'h0003_0004, 32'h3333_3333); bif.dest_credit = 4'b1000;
    at_neg(); chk("t6_yumi", 64'(bif.cmd_yumi), 64'(1));
    push_dsp(4'b1000, 32'h0003_0004, 32'h3333_3333);
    at_pos();
    chk("t6_credit3", 64'(dut.r_credit[3]), 64'(8));
    chk("t6_no_err", 64'(bif.credit_err), 64'(0));
    cmd(1'b0, '0, '0); bif.dest_credit = '0;
    cyc();
    bif.dest_credit = 4'b1000;
    cyc();
    bif.dest_credit = '0;
    chk("t6_err", 64'(bif.credit_err), 64'(1));
    chk("t6_credit3_hold", 64'(dut.r_credit[3]), 64'(8));
    cyc();
    chk("t6_err_sticky", 64'(bif.credit_err), 64'(1));

    // reset asserted mid-stall takes effect before the next edge
    bif.dest_ready = '0;
    cmd(1'b1, 32'h0000_0040, 32'h4444_4444);
    at_neg(); chk("t7_yumi", 64'(bif.cmd_yumi), 64'(1)); at_pos();
    cmd(1'b1, 32'h0002_0044, 32'h4444_5555);
    bif.ret_v = 4'b0010; bif.mrg_ready = 1'b0;
    at_neg();
    chk("t7_stall", 64'(bif.cmd_yumi), 64'(0));
    chk("t7_mrg_v", 64'(bif.mrg_v), 64'(1));
    at_pos();
    bif.mrg_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("t7_dest_v", 64'(bif.dest_v), 64'(0));
    chk("t7_addr", 64'(bif.dest_addr), 64'(0));
    chk("t7_data", 64'(bif.dest_data), 64'(0));
    chk("t7_yumi_rst", 64'(bif.cmd_yumi), 64'(0));
    chk("t7_mrg_v_rst", 64'(bif.mrg_v), 64'(0));
    chk("t7_ret_yumi", 64'(bif.ret_yumi), 64'(0));
    chk("t7_drop", 64'(bif.drop_count), 64'(0));
    chk("t7_err", 64'(bif.credit_err), 64'(0));
    chk("t7_credit0", 64'(dut.r_credit[0]), 64'(8));
    cmd(1'b0, '0, '0); bif.ret_v = '0; bif.mrg_ready = 1'b0; bif.dest_ready = '1;
    at_pos(); at_pos();
    rst_n = 1'b1;

    cmd(1'b1, 32'h0003_0008, 32'h5555_5555);
    at_neg(); chk("t8_yumi", 64'(bif.cmd_yumi), 64'(1));
    push_dsp(4'b1000, 32'h0003_0008, 32'h5555_5555);
    at_pos(); chk("t8_credit3", 64'(dut.r_credit[3]), 64'(7));
    cmd(1'b0, '0, '0);
    cyc();

    chk("dsp_sb_drained", 64'(dsp_q.size()), 64'(0));
    chk("ret_sb_drained", 64'(ret_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bsg_fifo_dest_scheduler.md
Name: bsg_fifo_dest_scheduler

Overview:
- Sits on the core-clock side of the PCIe AXI-lite-to-FIFO bridge.
- Takes the single (addr, data) command stream, decodes a destination index from address bits, and dispatches each command to one of num_dest_p endpoints under per-endpoint credit flow control.
- Merges the endpoints' return-data streams into the single bridge return FIFO using round-robin arbitration.

Parameters:
- num_dest_p, 4, number of endpoints, 1..16.
- addr_width_p, 32, command address width.
- data_width_p, 32, command and return data width.
- dest_sel_lsb_p, 16, LSB of the destination-select field in addr_i.
- dest_sel_width_p, 4, width of the select field; must satisfy 2**dest_sel_width_p >= num_dest_p.
- max_credits_p, 8, initial and maximum credits per endpoint.

Ports:
- clk_i  in  1  core clock; the only clock.
- reset_n_i  in  1  asynchronous active-low reset.
- v_i  in  1  command valid from the bridge FIFO output.
- addr_i  in  addr_width_p  command address.
- data_i  in  data_width_p  command data.
- yumi_o  out  1  command consumed this cycle.
- dest_v_o  out  num_dest_p  one-hot command valid per endpoint (registered).
- dest_addr_o  out  addr_width_p  shared registered command address.
- dest_data_o  out  data_width_p  shared registered command data.
- dest_ready_i  in  num_dest_p  endpoint accepts its command; handshake is dest_v_o[k] & dest_ready_i[k].
- dest_credit_i  in  num_dest_p  one-cycle pulse per returned credit.
- ret_v_i  in  num_dest_p  endpoint return data valid.
- ret_data_i  in  num_dest_p*data_width_p  endpoint return data, packed with endpoint k at bits [k*data_width_p +: data_width_p].
- ret_yumi_o  out  num_dest_p  return data consumed.
- v_o  out  1  merged return valid, to the bridge FIFO input.
- data_o  out  data_width_p  merged return data.
- ready_i  in  1  bridge return FIFO ready.
- drop_count_o  out  16  saturating count of commands dropped for a bad destination.
- credit_err_o  out  1  sticky flag: a credit was returned while the counter was already at max.

Behaviour:
- Reset (asynchronous, reset_n_i=0):
  - dest_v_o=0, dest_addr_o=0, dest_data_o=0.
  - All credit counters = max_credits_p.
  - Round-robin pointer = 0; drop_count_o=0; credit_err_o=0.
  - Combinational outputs (yumi_o, ret_yumi_o, v_o) are 0 while reset is asserted.
- Destination decode: sel = addr_i[dest_sel_lsb_p +: dest_sel_width_p].
- Dispatch stage: one output register, states EMPTY and FULL.
  - stage_free = EMPTY, or FULL with dest_v_o[cur] & dest_ready_i[cur] this cycle.
  - If v_i and sel < num_dest_p: yumi_o = stage_free & (credit[sel] != 0).
  - On yumi_o, the next cycle holds dest_v_o = onehot(sel) and addr/data are captured. Latency is one cycle from accept to dest_v_o.
  - If v_i and sel >= num_dest_p: yumi_o=1 regardless of stage and credits. The command is dropped and drop_count_o increments, saturating at 16'hFFFF.
  - FULL to EMPTY on handshake with no new accept. FULL to FULL on handshake plus a back-to-back accept, giving full throughput of one command per cycle.
  - dest_v_o, dest_addr_o and dest_data_o hold stable while FULL and not handshaken.
  - Zero credits for sel: yumi_o=0 and the command waits at the head. Head-of-line blocking is intended; ordering is preserved.
- Credit counters (width clog2(max_credits_p+1)), per endpoint:
  - Decrement on accept to that endpoint; increment on dest_credit_i.
  - Both in the same cycle: no change.
  - Increment at max_credits_p: counter holds and credit_err_o sets, cleared only by reset.
  - A decrement is never issued at 0, because the accept is gated.
- Return arbiter: combinational round-robin over ret_v_i.
  - Starts searching at the pointer, wrapping around from num_dest_p-1 to 0.
  - v_o = |ret_v_i; data_o = the winner's data.
  - ret_yumi_o = onehot(winner) & ready_i.
  - On ret_yumi_o the pointer becomes winner+1 mod num_dest_p; otherwise it is unchanged.
  - With no ret_v_i: v_o=0 and data_o=0.
- Reset mid-operation: the staged command and all in-flight credits are discarded. Endpoints must be reset together with this block.

Decomposition:
- Shared package bsg_fifo_dest_pkg holds:
  - the default dest_sel_lsb/width constants;
  - the drop counter width constant (16);
  - the typedef for the command struct {addr, data}.
- One sub-module, bsg_fifo_dest_rr_arb: parameterised round-robin arbiter with v_i, grant_o and yumi_i inputs/outputs and an internal pointer. It is reusable by other merge points.

Test Plan:
- Single command addr=32'h0002_0000, data=32'hA5A5A5A5, dest_ready_i=all 1 → yumi_o in cycle 0; dest_v_o=4'b0100 in cycle 1 with matching addr and data; credit[2]=7.
- 9 back-to-back commands to dest 1, no dest_credit_i → first 8 dispatched on consecutive cycles; 9th stalls with yumi_o=0. One dest_credit_i[1] pulse → 9th dispatched the next cycle.
- dest_ready_i[0]=0 for 5 cycles with a command to dest 0 staged → dest_v_o/addr/data stable for 5 cycles; no new accept. Release → handshake, then the next command follows back to back.
- num_dest_p=4, addr sel=4'hC → yumi_o=1, no dest_v_o, drop_count_o=1. 70000 such commands → drop_count_o saturates at 16'hFFFF.
- ret_v_i=4'b1111 held, ready_i=1, distinct data per endpoint → grants in order 0,1,2,3,0. Toggling ready_i=0 freezes the pointer.
- Same-cycle accept to dest 3 and dest_credit_i[3] → credit[3] unchanged. Credit pulse at max → credit_err_o=1 until reset_n_i low. Asserting reset mid-stall → all outputs return to reset values immediately, before the next clk_i edge.
